// File: rtl/cnn_max_pool_if.sv
// cnn_max_pool_if
//   Bundles the stream and status signals of the 2x2 max-pooling stage.
//   master : upstream/controller side (drives Start, in_valid, in_data)
//   slave  : pooling stage side (drives out_valid, out_data, busy, done)
// Handshake: valid-only stream. A sample transfers on every rising clk edge
//   where in_valid is high and the stage is in RUN. There is no ready; the
//   stage never back-pressures. out_valid is a one-cycle strobe and out_data
//   holds its value until the next strobe.
interface cnn_max_pool_if #(
   parameter int DW = 22
);
   logic                 Start;
   logic                 in_valid;
   logic signed [DW-1:0] in_data;
   logic                 out_valid;
   logic signed [DW-1:0] out_data;
   logic                 busy;
   logic                 done;

   modport master (
      output Start, in_valid, in_data,
      input  out_valid, out_data, busy, done
   );

   modport slave (
      input  Start, in_valid, in_data,
      output out_valid, out_data, busy, done
   );
endinterface

// File: rtl/cnn_max_pool.sv
// cnn_max_pool
//   2x2, stride-2 max pooling over a raster-order stream of signed conv results.
//   Even rows: pair maxima are parked in a half-row line buffer.
//   Odd rows : pair maximum is combined with the buffered one and emitted.
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   pool_if     : slave modport of cnn_max_pool_if (Start, in_valid, in_data,
//                 out_valid, out_data, busy, done)
//   dbg_state_o : current FSM state (IDLE=0, RUN=1, FLUSH=2, DONE=3)
module cnn_max_pool #(
   parameter int DW    = 22,
   parameter int MAP_W = 4,
   parameter int MAP_H = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   cnn_max_pool_if.slave      pool_if,
   output logic [1:0]         dbg_state_o
);

   localparam int CW   = $clog2(MAP_W);
   localparam int RW   = $clog2(MAP_H);
   localparam int LB_N = MAP_W / 2;
   localparam int LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        col_q;
   logic [RW-1:0]        row_q;
   logic signed [DW-1:0] pair_q;
   logic signed [DW-1:0] lb_q [LB_N];
   logic signed [DW-1:0] out_data_q;
   logic                 out_valid_q;
   logic                 busy_q;
   logic                 done_q;

   logic [LBW-1:0]       lb_idx;
   logic signed [DW-1:0] pair_max_d;
   logic signed [DW-1:0] pool_max_d;
   logic                 last_col;
   logic                 last_row;

   assign lb_idx   = LBW'(col_q >> 1);
   assign last_col = (col_q == CW'(MAP_W - 1));
   assign last_row = (row_q == RW'(MAP_H - 1));

   // Strict '>' keeps the earlier operand on ties; either choice gives the same value.
   always_comb begin
      pair_max_d = pair_q;
      if (pool_if.in_data > pair_q) begin
         pair_max_d = pool_if.in_data;
      end
      pool_max_d = lb_q[lb_idx];
      if (pair_max_d > lb_q[lb_idx]) begin
         pool_max_d = pair_max_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         pair_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int i = 0; i < LB_N; i++) begin
            lb_q[i] <= '0;
         end
      end else begin
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         // Start overrides everything, including a sample arriving in the same
         // cycle; a partially filled window is simply abandoned.
         if (pool_if.Start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            col_q   <= '0;
            row_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
               end
               RUN: begin
                  if (pool_if.in_valid) begin
                     if (!col_q[0]) begin
                        pair_q <= pool_if.in_data;
                     end else if (!row_q[0]) begin
                        lb_q[lb_idx] <= pair_max_d;
                     end else begin
                        out_data_q  <= pool_max_d;
                        out_valid_q <= 1'b1;
                     end
                     if (last_col) begin
                        col_q <= '0;
                        if (last_row) begin
                           row_q   <= '0;
                           state_q <= FLUSH;
                           busy_q  <= 1'b0;
                        end else begin
                           row_q <= row_q + 1'b1;
                        end
                     end else begin
                        col_q <= col_q + 1'b1;
                     end
                  end
               end
               // FLUSH lets the final out_valid strobe go out before done.
               FLUSH: begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end
               DONE: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign pool_if.out_valid = out_valid_q;
   assign pool_if.out_data  = out_data_q;
   assign pool_if.busy      = busy_q;
   assign pool_if.done      = done_q;
   assign dbg_state_o       = state_q;

endmodule
